// File: rtl/rv32_data_mem_controller_if.sv
// Core-side request/response and SRAM-side signals of the data memory controller.
// slave is the controller's view; master is the core+SRAM (environment) view.
interface rv32_data_mem_controller_if #(
  parameter int AW = 10
);
  logic          core_req;
  logic          core_ready;
  logic [31:0]   core_addr;
  logic          core_wr_ena;
  logic [2:0]    core_access;
  logic [31:0]   core_wr_data;
  logic [31:0]   core_rd_data;
  logic          core_done;
  logic [1:0]    core_exception;
  logic [AW-1:0] ram_addr;
  logic          ram_wr_ena;
  logic [31:0]   ram_wr_data;
  logic [31:0]   ram_rd_data;

  modport slave (
    input  core_req, core_addr, core_wr_ena, core_access, core_wr_data, ram_rd_data,
    output core_ready, core_rd_data, core_done, core_exception,
           ram_addr, ram_wr_ena, ram_wr_data
  );

  modport master (
    output core_req, core_addr, core_wr_ena, core_access, core_wr_data, ram_rd_data,
    input  core_ready, core_rd_data, core_done, core_exception,
           ram_addr, ram_wr_ena, ram_wr_data
  );
endinterface

// File: rtl/rv32_data_mem_controller.sv
// RV32 data memory controller: one load/store at a time on a 1-cycle synchronous SRAM, RMW for sub-word stores.
// Latency load +3, word store +2, byte/half store +4, exception +1; ena=0 freezes. Optional counters: DATA_MEM_CTRL_STATS_EN.
module rv32_data_mem_controller #(
  parameter logic [3:0] BANK        = 4'h1,
  parameter int         DEPTH_WORDS = 1024,
  parameter int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  rv32_data_mem_controller_if.slave bus
`ifdef DATA_MEM_CTRL_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_exceptions
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  localparam logic [2:0] A_BYTE   = 3'd0;
  localparam logic [2:0] A_HALF   = 3'd1;
  localparam logic [2:0] A_WORD   = 3'd2;
  localparam logic [2:0] A_BYTE_U = 3'd4;
  localparam logic [2:0] A_HALF_U = 3'd5;

  state_t        r_state, w_next;
  logic [AW+1:0] r_addr;
  logic          r_wr;
  logic [2:0]    r_access;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [1:0]    r_exc;

  logic          w_misal, w_oor;
  logic [31:0]   w_lane, w_load, w_merge;
  logic          w_unused_addr;

  // With a power-of-two depth the word index always fits, so only the bank nibble can be out of range.
  assign w_oor         = bus.core_addr[31:28] != BANK;
  assign w_unused_addr = &{1'b0, bus.core_addr[27:AW+2]};

  always_comb begin
    w_misal = 1'b0;
    case (bus.core_access)
      A_BYTE, A_BYTE_U: w_misal = 1'b0;
      A_HALF, A_HALF_U: w_misal = bus.core_addr[0];
      A_WORD:           w_misal = |bus.core_addr[1:0];
      default:          w_misal = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.core_req) begin
          if (w_misal || w_oor)                               w_next = S_DONE;
          else if (bus.core_wr_ena && bus.core_access == A_WORD) w_next = S_WRITE;
          else                                                w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = r_wr ? S_WRITE : S_DONE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_access <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_exc    <= '0;
    end else if (ena) begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.core_req) begin
        r_addr   <= bus.core_addr[AW+1:0];
        r_wr     <= bus.core_wr_ena;
        r_access <= bus.core_access;
        r_wdata  <= bus.core_wr_data;
        r_exc    <= {w_oor, w_misal};
      end
      if (r_state == S_WAIT) r_rdata <= bus.ram_rd_data;
    end
  end

  // Stores ignore the unsigned flag, so only access[1:0] selects the lane width.
  always_comb begin
    w_merge = r_rdata;
    case (r_access[1:0])
      2'd0:    w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'd1:    w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merge = r_wdata;
    endcase
  end

  assign w_lane = r_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_access)
      A_BYTE:   w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      A_BYTE_U: w_load = {24'd0, w_lane[7:0]};
      A_HALF:   w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      A_HALF_U: w_load = {16'd0, w_lane[15:0]};
      default:  w_load = r_rdata;
    endcase
  end

  assign bus.core_ready     = r_state == S_IDLE;
  assign bus.core_done      = (r_state == S_DONE) && ena && !rst;
  assign bus.core_exception = (r_state == S_DONE) ? r_exc : 2'b00;
  assign bus.core_rd_data   = (r_state == S_DONE && !r_wr && r_exc == 2'b00) ? w_load : 32'd0;
  assign bus.ram_addr       = r_addr[AW+1:2];
  assign bus.ram_wr_ena     = (r_state == S_WRITE) && ena && !rst;
  assign bus.ram_wr_data    = (r_state == S_WRITE) ? w_merge : 32'd0;

`ifdef DATA_MEM_CTRL_STATS_EN
  logic [31:0] r_stat_loads, r_stat_stores, r_stat_exceptions;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_loads      <= '0;
      r_stat_stores     <= '0;
      r_stat_exceptions <= '0;
    end else if (ena && r_state == S_DONE) begin
      if (|r_exc)    r_stat_exceptions <= r_stat_exceptions + 32'd1;
      else if (r_wr) r_stat_stores     <= r_stat_stores + 32'd1;
      else           r_stat_loads      <= r_stat_loads + 32'd1;
    end
  end

  assign stat_loads      = r_stat_loads;
  assign stat_stores     = r_stat_stores;
  assign stat_exceptions = r_stat_exceptions;
`endif

endmodule

// File: tb/tb_rv32_data_mem_controller.sv
// Bench for rv32_data_mem_controller: directed cases plus random loads/stores against a byte-lane memory model.
// Build with +define+DATA_MEM_CTRL_STATS_EN to also check the counters.
module tb_rv32_data_mem_controller;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  always #5 clk = ~clk;

  rv32_data_mem_controller_if #(.AW(AW)) bus();

`ifdef DATA_MEM_CTRL_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_exceptions;
  int m_loads = 0, m_stores = 0, m_excs = 0;
`endif

  rv32_data_mem_controller #(.BANK(4'h1), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .bus(bus)
`ifdef DATA_MEM_CTRL_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_exceptions(stat_exceptions)
`endif
  );

  // Synchronous SRAM with a side port so the bench can preset words.
  logic [31:0] sram    [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        poke_en = 1'b0;
  int          poke_idx = 0;
  logic [31:0] poke_dat = '0;
  always @(posedge clk) begin
    if (poke_en) sram[poke_idx] <= poke_dat;
    else if (bus.ram_wr_ena) sram[bus.ram_addr] <= bus.ram_wr_data;
    bus.ram_rd_data <= sram[bus.ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  bit chk_on = 1'b0;
  int exp_done = -1, exp_wr = -1, busy_from = 1, busy_to = 0;
  logic [31:0] exp_rd = '0, exp_wdat = '0;
  logic [1:0]  exp_exc = '0;
  logic [AW-1:0] exp_waddr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Memory model: plain byte-lane arithmetic on ref_mem.
  function automatic void model(input logic [31:0] a, input logic w, input logic [2:0] acc,
                                input logic [31:0] wd, output logic [1:0] exc,
                                output logic [31:0] rd, output logic [31:0] neww);
    int size, sh;
    logic [31:0] word, mask, v;
    size = (acc == 0 || acc == 4) ? 1 : (acc == 1 || acc == 5) ? 2 : (acc == 2) ? 4 : 0;
    exc[0] = (size == 0) ? 1'b1 : ((a % size) != 0);
    exc[1] = a[31:28] != 4'h1;
    word = ref_mem[a[11:2]];
    sh   = int'(a[1:0]) * 8;
    mask = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    v    = (word >> sh) & mask;
    rd   = 32'd0;
    if (!w && exc == 2'b00) begin
      case (acc)
        3'd0:    rd = v[7]  ? (v | 32'hFFFF_FF00) : v;
        3'd1:    rd = v[15] ? (v | 32'hFFFF_0000) : v;
        default: rd = v;
      endcase
    end
    neww = (word & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a, input logic [2:0] acc);
    logic [1:0] e; logic [31:0] r, n;
    model(a, 1'b0, acc, 32'd0, e, r, n);
    return r;
  endfunction
  function automatic logic [1:0] m_exc(input logic [31:0] a, input logic [2:0] acc);
    logic [1:0] e; logic [31:0] r, n;
    model(a, 1'b0, acc, 32'd0, e, r, n);
    return e;
  endfunction
  function automatic logic [31:0] m_new(input logic [31:0] a, input logic [2:0] acc, input logic [31:0] wd);
    logic [1:0] e; logic [31:0] r, n;
    model(a, 1'b1, acc, wd, e, r, n);
    return n;
  endfunction

  // Single compare process: every cycle, DUT outputs versus the current expectation window.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", 32'(bus.core_ready), 32'(!(cyc >= busy_from && cyc <= busy_to)));
      chk("done", 32'(bus.core_done), 32'(cyc == exp_done));
      if (cyc == exp_done) begin
        chk("rd_data", bus.core_rd_data, exp_rd);
        chk("exception", 32'(bus.core_exception), 32'(exp_exc));
      end
      chk("wr_ena", 32'(bus.ram_wr_ena), 32'(cyc == exp_wr));
      if (cyc == exp_wr) begin
        chk("wr_addr", 32'(bus.ram_addr), 32'(exp_waddr));
        chk("wr_data", bus.ram_wr_data, exp_wdat);
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] d);
    poke_idx = idx; poke_dat = d; poke_en = 1'b1;
    ref_mem[idx] = d;
    @(negedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic drive_garbage(input bit on);
    bus.core_req     = on ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.core_addr    = $urandom;
    bus.core_wr_ena  = 1'($urandom_range(0, 1));
    bus.core_access  = 3'($urandom_range(0, 7));
    bus.core_wr_data = $urandom;
  endtask

  // Issue one request; stall = ena-low cycles while in the read-wait cycle; rst_w = reset during the write cycle.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [2:0] acc,
                         input logic [31:0] wd, input int stall, input bit rst_w, input bit garbage);
    int c, lat, wl, span;
    logic [1:0] e; logic [31:0] r, n;
    model(a, w, acc, wd, e, r, n);
    lat = (e != 0) ? 1 : !w ? 3 : (acc == 3'd2) ? 2 : 4;
    wl  = (e != 0 || !w) ? -1 : (acc == 3'd2) ? 1 : 3;
    if (stall > 0) begin
      lat += stall;
      if (wl > 2) wl += stall;
    end
    @(negedge clk); #1;
    c = cyc;
    exp_rd = r; exp_exc = e; exp_wdat = n; exp_waddr = a[11:2];
    busy_from = c + 1;
    if (rst_w) begin
      exp_done = -1; exp_wr = -1; busy_to = c + 3; span = 4;
    end else begin
      exp_done = c + lat; exp_wr = (wl < 0) ? -1 : c + wl; busy_to = c + lat; span = lat;
      if (wl >= 0) ref_mem[a[11:2]] = n;
`ifdef DATA_MEM_CTRL_STATS_EN
      if (e != 0) m_excs++; else if (w) m_stores++; else m_loads++;
`endif
    end
    bus.core_req = 1'b1; bus.core_addr = a; bus.core_wr_ena = w;
    bus.core_access = acc; bus.core_wr_data = wd;
    for (int k = 1; k <= span; k++) begin
      @(negedge clk); #1;
      drive_garbage(garbage && k < span);
      if (stall > 0 && k == 2) ena = 1'b0;
      if (stall > 0 && k == 2 + stall) ena = 1'b1;
      if (rst_w && k == 2) begin
        @(posedge clk); #1;
        rst = 1'b1;
      end
      if (rst_w && k == 4) begin
        rst = 1'b0;
`ifdef DATA_MEM_CTRL_STATS_EN
        m_loads = 0; m_stores = 0; m_excs = 0;
`endif
      end
    end
  endtask

  logic [2:0]  acc_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3, 3'd6, 3'd7};
  logic [31:0] ra, rwd;
  logic        rw;
  logic [2:0]  racc;

  initial begin
    drive_garbage(1'b0);
    for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
    @(negedge clk);
    chk("rst_ready", 32'(bus.core_ready), 32'd1);
    chk("rst_done", 32'(bus.core_done), 32'd0);
    chk("rst_exc", 32'(bus.core_exception), 32'd0);
    chk("rst_rd", bus.core_rd_data, 32'd0);
    chk("rst_wr_ena", 32'(bus.ram_wr_ena), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_wr_data", bus.ram_wr_data, 32'd0);
    #1 rst = 1'b0;
    chk_on = 1'b1;

    poke(16, 32'h8899_AABB);
    chk("pin_ld_byte", m_rd(32'h1000_0041, 3'd0), 32'hFFFF_FFAA);
    run_txn(32'h1000_0041, 1'b0, 3'd0, 32'd0, 0, 1'b0, 1'b0);
    chk("pin_ld_byte_u", m_rd(32'h1000_0041, 3'd4), 32'h0000_00AA);
    run_txn(32'h1000_0041, 1'b0, 3'd4, 32'd0, 0, 1'b0, 1'b1);

    poke(16, 32'hDEAD_BEEF);
    chk("pin_st_half", m_new(32'h1000_0042, 3'd1, 32'h0000_1234), 32'h1234_BEEF);
    run_txn(32'h1000_0042, 1'b1, 3'd1, 32'h0000_1234, 0, 1'b0, 1'b0);

    run_txn(32'h1000_0000, 1'b1, 3'd2, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
    chk("pin_ld_word", m_rd(32'h1000_0000, 3'd2), 32'hCAFE_F00D);
    run_txn(32'h1000_0000, 1'b0, 3'd2, 32'd0, 0, 1'b0, 1'b0);

    chk("pin_misal", 32'(m_exc(32'h1000_0002, 3'd2)), 32'd1);
    run_txn(32'h1000_0002, 1'b0, 3'd2, 32'd0, 0, 1'b0, 1'b0);
    chk("pin_oor", 32'(m_exc(32'h2000_0000, 3'd2)), 32'd2);
    run_txn(32'h2000_0000, 1'b0, 3'd2, 32'd0, 0, 1'b0, 1'b1);

    poke(17, 32'h0102_0304);
    chk("pin_st_byte", m_new(32'h1000_0045, 3'd0, 32'h0000_0077), 32'h0102_7704);
    run_txn(32'h1000_0045, 1'b1, 3'd0, 32'h0000_0077, 3, 1'b0, 1'b0);
    run_txn(32'h1000_0046, 1'b1, 3'd0, 32'h0000_0055, 0, 1'b1, 1'b0);
    chk("pin_after_rst", m_rd(32'h1000_0046, 3'd4), 32'h0000_0002);
    run_txn(32'h1000_0046, 1'b0, 3'd4, 32'd0, 0, 1'b0, 1'b0);

`ifdef DATA_MEM_CTRL_STATS_EN
    run_txn(32'h1000_0040, 1'b0, 3'd2, 32'd0, 0, 1'b0, 1'b0);
    run_txn(32'h1000_0044, 1'b1, 3'd0, 32'h0000_00A5, 0, 1'b0, 1'b0);
    run_txn(32'h1000_0043, 1'b0, 3'd1, 32'd0, 0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("stat_loads_dir", stat_loads, 32'd2);
    chk("stat_stores_dir", stat_stores, 32'd1);
    chk("stat_exc_dir", stat_exceptions, 32'd1);
`endif

    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      ra[31:28] = ($urandom_range(0, 7) == 0) ? 4'h2 : 4'h1;
      if ($urandom_range(0, 3) != 0) ra[11:2] = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 1) != 0) ra[1:0] = 2'b00;
      racc = acc_tab[$urandom_range(0, 9)];
      rw   = 1'($urandom_range(0, 1));
      rwd  = $urandom;
      run_txn(ra, rw, racc, rwd, 0, 1'b0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #1;
      end
    end

    @(negedge clk); #1;
`ifdef DATA_MEM_CTRL_STATS_EN
    chk("stat_loads", stat_loads, 32'(m_loads));
    chk("stat_stores", stat_stores, 32'(m_stores));
    chk("stat_exc", stat_exceptions, 32'(m_excs));
`endif
    for (int i = 0; i < 16; i++) chk("mem_final", sram[i], ref_mem[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32_data_mem_controller.md
Name: rv32_data_mem_controller

Overview:
- Downstream of the rv32i multicycle core's memory port.
- Accepts one load/store request at a time and checks alignment and address range.
- Performs the access on a word-addressed synchronous SRAM (1-cycle read latency), using read-modify-write for byte/halfword stores.
- Returns sign/zero-extended load data with a one-cycle done pulse and an exception mask.

Parameters:
- BANK, 4'h1: required value of address bits [31:28].
- DEPTH_WORDS, 1024: SRAM depth in 32-bit words (power of two).
- AW, $clog2(DEPTH_WORDS): SRAM word-address width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; low freezes all state.
- core_req  in  1  request valid; sampled only in S_IDLE.
- core_ready  out  1  high iff state is S_IDLE.
- core_addr  in  32  byte address.
- core_wr_ena  in  1  1 = store, 0 = load.
- core_access  in  3  access type: 0 BYTE, 1 HALF, 2 WORD, 4 BYTE_U, 5 HALF_U (U types are for loads only).
- core_wr_data  in  32  store data, right-aligned.
- core_rd_data  out  32  extended load data; valid while core_done is high.
- core_done  out  1  one-cycle completion pulse.
- core_exception  out  2  bit0 misaligned, bit1 out-of-range; valid while core_done is high.
- ram_addr  out  AW  SRAM word address.
- ram_wr_ena  out  1  SRAM write strobe.
- ram_wr_data  out  32  SRAM write word.
- ram_rd_data  in  32  SRAM read word; valid one cycle after ram_addr is driven with ram_wr_ena=0.

Behaviour:
- Reset (rst=1 at a posedge):
  - state returns to S_IDLE; all latched request/data registers are cleared.
  - core_done=0, core_exception=0, core_rd_data=0, ram_wr_ena=0, ram_addr=0, ram_wr_data=0.
  - rst takes priority over everything: any in-flight access is abandoned, and ram_wr_ena is forced 0 in a cycle where rst=1.
- ena=0: state and registers hold; ram_wr_ena forced 0; core_done forced 0. The done pulse is delivered on the next ena=1 cycle.
- States: S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE.
- S_IDLE, on core_req=1:
  - Latch addr, wr_ena, access, wr_data; compute the exception mask.
  - Misaligned: HALF/HALF_U with addr[0]=1, or WORD with addr[1:0]!=0.
  - Out-of-range: addr[31:28]!=BANK, or addr[AW+1:2] index >= DEPTH_WORDS.
  - Next state: any exception -> S_DONE; word store -> S_WRITE; otherwise -> S_READ.
- S_READ: ram_addr = latched addr[AW+1:2]; ram_wr_ena=0 -> S_WAIT.
- S_WAIT: latch ram_rd_data into rdata_q; store -> S_WRITE, load -> S_DONE.
- S_WRITE:
  - ram_wr_ena=1.
  - ram_wr_data = wr_data for WORD; otherwise rdata_q with the byte lane addr[1:0] (BYTE) or half lane addr[1] (HALF) replaced by wr_data[7:0] or wr_data[15:0].
  - Next state: S_DONE.
- S_DONE:
  - core_done=1 for exactly one cycle.
  - Load core_rd_data: selected lane, sign-extended for BYTE/HALF, zero-extended for BYTE_U/HALF_U; WORD passes through.
  - Store core_rd_data = 0.
  - On any exception, core_rd_data=0 and the SRAM is never written.
  - Next state: S_IDLE.
- Latency in cycles after the accept edge, with ena held high:
  - load: done at +3.
  - word store: done at +2.
  - byte/half store: done at +4.
  - exception: done at +1.
- Back-to-back requests: the earliest next acceptance is the cycle after S_DONE (core_ready is high again).
- core_req outside S_IDLE is ignored. Requests are not queued.
- Invalid access codes (3, 6, 7) are treated as misaligned.
- BYTE_U/HALF_U used with a store: treated as BYTE/HALF.

Optional Feature:
- Macro: DATA_MEM_CTRL_STATS_EN.
- With the macro defined:
  - Extra outputs stat_loads, stat_stores, stat_exceptions, each 32 bits.
  - Each counter increments by 1 in the S_DONE cycle of the matching outcome; an exception counts only in stat_exceptions.
  - Counters wrap at 2^32, reset to 0 on rst, and hold when ena=0.
- Without the macro: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Pre-load word 0x10 = 0x8899AABB. LOAD BYTE at addr 0x1000_0041 -> done at +3, core_rd_data=0xFFFFFFAA, exception=0. Same with BYTE_U -> 0x000000AA.
- STORE HALF 0x1234 at 0x1000_0042 onto 0xDEADBEEF -> ram_wr_ena pulses once at +3 with 0x1234BEEF; done at +4.
- STORE WORD 0xCAFEF00D at 0x1000_0000 -> no read cycle; ram_wr_ena at +1; done at +2; a following word load returns 0xCAFEF00D.
- LOAD WORD at 0x1000_0002 -> done at +1, exception=2'b01. LOAD at 0x2000_0000 -> exception=2'b10. Neither produces a ram_wr_ena pulse.
- Byte store with ena held 0 for 3 cycles in S_WAIT -> the outputs of the held state are held, no write occurs, and completion is delayed by exactly 3 cycles. With rst=1 asserted in S_WRITE -> no write and state returns to S_IDLE.
- With DATA_MEM_CTRL_STATS_EN: 2 loads, 1 store, 1 misaligned access -> stat_loads=2, stat_stores=1, stat_exceptions=1.
